// File: rtl/intl_trip_seq_pkg.sv
// rtl/intl_trip_seq_pkg.sv - shared state encodings, timing defaults and helpers for the interlock trip sequencer
package intl_trip_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_TRIP      = 2'd1,
        ST_RST_PULSE = 2'd2,
        ST_SETTLE    = 2'd3
    } seq_state_e;

    // Raw encodings mirrored into the PS status register
    localparam logic [1:0] SEQ_RUN       = 2'd0;
    localparam logic [1:0] SEQ_TRIP      = 2'd1;
    localparam logic [1:0] SEQ_RST_PULSE = 2'd2;
    localparam logic [1:0] SEQ_SETTLE    = 2'd3;

    localparam int DEF_RST_PULSE   = 100;
    localparam int DEF_SETTLE      = 10000;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/intl_sync_edge.sv
// rtl/intl_sync_edge.sv - optional multi-flop synchronizer followed by a rising-edge detector
module intl_sync_edge #(
    parameter int P_STAGES = 2,
    parameter bit P_BYPASS = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic level;
    logic prev;

    generate
        if (P_BYPASS) begin : g_bypass
            assign level = i_d;
        end else begin : g_sync
            logic [P_STAGES-1:0] sync_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[P_STAGES-2:0], i_d};
                end
            end
            assign level = sync_q[P_STAGES-1];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign o_rise = level & ~prev;

endmodule

// File: rtl/intl_trip_seq.sv
// rtl/intl_trip_seq.sv - interlock trip sequencer: fault capture, PWM enable and timed clear sequence
module intl_trip_seq
    import intl_trip_seq_pkg::*;
#(
    parameter int P_RST_PULSE   = DEF_RST_PULSE,
    parameter int P_SETTLE      = DEF_SETTLE,
    parameter int P_SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_intl_state,
    input  logic [31:0] i_intl_mask,
    input  logic        i_clr_req,
    input  logic        i_sys_rst_flag,
    output logic        o_pwm_en,
    output logic        o_trip,
    output logic        o_intl_clr,
    output logic        o_oc_rst,
    output logic [31:0] o_first_fault,
    output logic [31:0] o_fault_latch,
    output logic        o_clr_ack,
    output logic        o_clr_fail,
    output logic [15:0] o_trip_cnt,
    output logic [1:0]  o_seq_state
);

    localparam int RCW = (P_RST_PULSE > 1) ? $clog2(P_RST_PULSE) : 1;
    localparam int SCW = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
    localparam logic [RCW-1:0] RST_LAST    = RCW'(P_RST_PULSE - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(P_SETTLE - 1);

    seq_state_e     state;
    logic [RCW-1:0] rst_cnt;
    logic [SCW-1:0] settle_cnt;
    logic [31:0]    active;
    logic           fault_any;
    logic           dtr_rise;
    logic           ps_rise;
    logic           clr_req;

    assign active    = i_intl_state & ~i_intl_mask;
    assign fault_any = |active;

    intl_sync_edge #(
        .P_STAGES (P_SYNC_STAGES),
        .P_BYPASS (1'b0)
    ) u_dtr_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_sys_rst_flag),
        .o_rise (dtr_rise)
    );

    // PS register bit is already in this clock domain; only the edge is needed
    intl_sync_edge #(
        .P_STAGES (P_SYNC_STAGES),
        .P_BYPASS (1'b1)
    ) u_ps_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_clr_req),
        .o_rise (ps_rise)
    );

    assign clr_req = dtr_rise | ps_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_TRIP;
            o_pwm_en      <= 1'b0;
            o_trip        <= 1'b1;
            o_intl_clr    <= 1'b0;
            o_oc_rst      <= 1'b0;
            o_first_fault <= '0;
            o_fault_latch <= '0;
            o_clr_ack     <= 1'b0;
            o_clr_fail    <= 1'b0;
            o_trip_cnt    <= '0;
            rst_cnt       <= '0;
            settle_cnt    <= '0;
        end else begin
            o_intl_clr <= 1'b0;
            o_clr_ack  <= 1'b0;
            o_clr_fail <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (fault_any) begin
                        state         <= ST_TRIP;
                        o_pwm_en      <= 1'b0;
                        o_trip        <= 1'b1;
                        o_first_fault <= active;
                        o_fault_latch <= active;
                        o_trip_cnt    <= sat_inc16(o_trip_cnt);
                    end
                end
                ST_TRIP: begin
                    if (clr_req) begin
                        state         <= ST_RST_PULSE;
                        o_intl_clr    <= 1'b1;
                        o_oc_rst      <= 1'b1;
                        o_first_fault <= '0;
                        o_fault_latch <= '0;
                        rst_cnt       <= '0;
                    end else begin
                        o_fault_latch <= o_fault_latch | active;
                    end
                end
                ST_RST_PULSE: begin
                    // Faults are expected here while the OC latch is being reset
                    if (rst_cnt == RST_LAST) begin
                        o_oc_rst   <= 1'b0;
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (fault_any) begin
                        state         <= ST_TRIP;
                        o_first_fault <= active;
                        o_fault_latch <= active;
                        o_trip_cnt    <= sat_inc16(o_trip_cnt);
                        o_clr_fail    <= 1'b1;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state     <= ST_RUN;
                        o_clr_ack <= 1'b1;
                        o_pwm_en  <= 1'b1;
                        o_trip    <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                    end
                end
            endcase
        end
    end

    assign o_seq_state = state;

endmodule

// File: tb/tb_intl_trip_seq.sv
// tb/tb_intl_trip_seq.sv - directed self-checking bench for intl_trip_seq
`timescale 1ns/1ps
module tb_intl_trip_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] intl_state;
    logic [31:0] intl_mask;
    logic        clr_req;
    logic        sys_rst_flag;
    logic        pwm_en;
    logic        trip;
    logic        intl_clr;
    logic        oc_rst;
    logic [31:0] first_fault;
    logic [31:0] fault_latch;
    logic        clr_ack;
    logic        clr_fail;
    logic [15:0] trip_cnt;
    logic [1:0]  seq_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    intl_trip_seq #(
        .P_RST_PULSE   (100),
        .P_SETTLE      (10000),
        .P_SYNC_STAGES (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_intl_state   (intl_state),
        .i_intl_mask    (intl_mask),
        .i_clr_req      (clr_req),
        .i_sys_rst_flag (sys_rst_flag),
        .o_pwm_en       (pwm_en),
        .o_trip         (trip),
        .o_intl_clr     (intl_clr),
        .o_oc_rst       (oc_rst),
        .o_first_fault  (first_fault),
        .o_fault_latch  (fault_latch),
        .o_clr_ack      (clr_ack),
        .o_clr_fail     (clr_fail),
        .o_trip_cnt     (trip_cnt),
        .o_seq_state    (seq_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_settle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (seq_state == 2'd3) ok = 1'b1;
        end
    endtask

    task automatic settle_fail_trip();
        logic ok;
        clr_req = 1'b0;
        @(negedge clk);
        clr_req = 1'b1;
        wait_settle(ok);
        chk("sat_reach_settle", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        intl_state = 32'h1;
        @(negedge clk);
        intl_state = 32'h0;
        chk("sat_fail_pulse", {31'd0, clr_fail}, 32'd1);
        clr_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  n_clr;
        int  n_oc;
        int  lat;
        logic got_ack;
        logic seen;
        logic ok;

        rst          = 1'b1;
        intl_state   = '0;
        intl_mask    = '0;
        clr_req      = 1'b0;
        sys_rst_flag = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pwm_en", {31'd0, pwm_en}, 32'd0);
        chk("rst_trip", {31'd0, trip}, 32'd1);
        chk("rst_state", {30'd0, seq_state}, 32'd1);
        chk("rst_trip_cnt", {16'd0, trip_cnt}, 32'd0);
        chk("rst_oc_rst", {31'd0, oc_rst}, 32'd0);

        // Power-up clear sequence
        clr_req = 1'b1;
        n_clr = 0; n_oc = 0; lat = 0; got_ack = 1'b0;
        for (int i = 1; i <= 12000 && !got_ack; i++) begin
            @(negedge clk);
            n_clr += int'(intl_clr);
            n_oc  += int'(oc_rst);
            if (clr_ack) begin
                got_ack = 1'b1;
                lat = i - 1;
            end
        end
        chk("clr_pulse_count", n_clr, 32'd1);
        chk("oc_rst_cycles", n_oc, 32'd100);
        chk("ack_latency", lat, 32'd10100);
        @(negedge clk);
        chk("run_pwm_en", {31'd0, pwm_en}, 32'd1);
        chk("run_state", {30'd0, seq_state}, 32'd0);
        chk("run_trip", {31'd0, trip}, 32'd0);

        // Masked fault bits are ignored
        intl_mask  = 32'h4;
        intl_state = 32'h5;
        @(negedge clk);
        chk("fault_pwm_off", {31'd0, pwm_en}, 32'd0);
        chk("fault_first", first_fault, 32'h1);
        chk("fault_cnt", {16'd0, trip_cnt}, 32'd1);
        chk("fault_state", {30'd0, seq_state}, 32'd1);
        intl_state = 32'h105;
        @(negedge clk);
        chk("accum_latch", fault_latch, 32'h101);
        chk("accum_first", first_fault, 32'h1);

        // Fault during settle window
        intl_state = '0;
        intl_mask  = '0;
        clr_req    = 1'b0;
        @(negedge clk);
        clr_req = 1'b1;
        wait_settle(ok);
        chk("reach_settle", {31'd0, ok}, 32'd1);
        repeat (500) @(negedge clk);
        intl_state = 32'h8;
        @(negedge clk);
        chk("settle_fail_pulse", {31'd0, clr_fail}, 32'd1);
        chk("settle_fail_state", {30'd0, seq_state}, 32'd1);
        chk("settle_fail_first", first_fault, 32'h8);
        chk("settle_fail_cnt", {16'd0, trip_cnt}, 32'd2);
        chk("settle_fail_pwm", {31'd0, pwm_en}, 32'd0);
        intl_state = '0;
        clr_req    = 1'b0;
        @(negedge clk);

        // DTR request, asynchronous to the clock
        #2 sys_rst_flag = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 && !seen; i++) begin
            @(negedge clk);
            if (intl_clr) seen = 1'b1;
        end
        chk("dtr_start", {31'd0, seen}, 32'd1);
        clr_req = 1'b1;
        n_clr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_clr += int'(intl_clr);
        end
        chk("dropped_req", n_clr, 32'd0);
        chk("mid_pulse_oc", {31'd0, oc_rst}, 32'd1);

        // Asynchronous reset mid-pulse
        #2 rst = 1'b1;
        #1;
        chk("arst_oc_rst", {31'd0, oc_rst}, 32'd0);
        chk("arst_state", {30'd0, seq_state}, 32'd1);
        chk("arst_cnt", {16'd0, trip_cnt}, 32'd0);
        chk("arst_latch", fault_latch, 32'd0);
        chk("arst_trip", {31'd0, trip}, 32'd1);
        sys_rst_flag = 1'b0;
        clr_req      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_state", {30'd0, seq_state}, 32'd1);
        chk("post_rst_cnt", {16'd0, trip_cnt}, 32'd0);

        // Saturating trip counter
        force dut.o_trip_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.o_trip_cnt;
        settle_fail_trip();
        chk("sat_first", {16'd0, trip_cnt}, 32'hFFFF);
        settle_fail_trip();
        chk("sat_hold", {16'd0, trip_cnt}, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
